// File: rtl/lava_pkg.sv
// Shared types and defaults for the LAVA result drain.
// LAVA_DRAIN_CHECKSUM_EN adds the CSUM state.
package lava_pkg;

  localparam int ADDR_W_D  = 3;
  localparam int DATA_W_D  = 8;
  localparam int RAM_DEPTH = 1 << ADDR_W_D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_FLUSH,
    S_DONE
`ifdef LAVA_DRAIN_CHECKSUM_EN
    , S_CSUM
`endif
  } drain_state_t;

endpackage

// File: rtl/lava_skid_fifo.sv
// Two-entry FIFO absorbing the RAM read latency
// between issue and a stalled consumer.
module lava_skid_fifo #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_occ;

  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_mem[r_rp];
  assign o_occ   = r_occ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (i_pop) begin
        r_rp <= ~r_rp;
      end
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

endmodule

// File: rtl/lava_result_drain.sv
// Streams result RAM contents out over valid/ready.
// LAVA_DRAIN_CHECKSUM_EN appends a sum-mod-256 beat.
module lava_result_drain
  import lava_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_rd_en,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  drain_state_t r_state, w_next;

  logic [ADDR_W:0]   r_rd_left;
  logic [ADDR_W:0]   r_beats_left;
  logic [ADDR_W:0]   w_cnt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_inflight;
  logic              r_infl_last;
  logic              w_issue;
  logic              w_pop;
  logic              w_xfer;
  logic              w_room;
  logic              w_fifo_valid;
  logic              w_fifo_last;
  logic [DATA_W-1:0] w_fifo_data;
  logic [1:0]        w_occ;
  logic [2:0]        w_pend;
`ifdef LAVA_DRAIN_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
`endif

  assign w_cnt   = (count > DEPTH) ? DEPTH : count;
  assign w_pop   = w_fifo_valid & out_ready;
  // Slots already claimed once this cycle's pop frees one.
  assign w_pend  = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_room  = (w_pend < 3'd2);
  assign w_issue = (r_state == S_READ) && (r_rd_left != '0) && w_room;

  assign ram_rd_en = w_issue;
  assign ram_raddr = r_rd_addr;

`ifdef LAVA_DRAIN_CHECKSUM_EN
  assign out_valid = w_fifo_valid | (r_state == S_CSUM);
  assign out_data  = (r_state == S_CSUM) ? r_csum : w_fifo_data;
  assign out_last  = (r_state == S_CSUM) | (w_fifo_valid & w_fifo_last);
`else
  assign out_valid = w_fifo_valid;
  assign out_data  = w_fifo_data;
  assign out_last  = w_fifo_valid & w_fifo_last;
`endif
  assign w_xfer = out_valid & out_ready;

  lava_skid_fifo #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_inflight),
    .i_data ({r_infl_last, ram_rdata}),
    .i_pop  (w_pop),
    .o_valid(w_fifo_valid),
    .o_data ({w_fifo_last, w_fifo_data}),
    .o_occ  (w_occ)
  );

  always_comb begin
    w_next = r_state;
    done   = 1'b0;
    busy   = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef LAVA_DRAIN_CHECKSUM_EN
          w_next = (w_cnt == '0) ? S_CSUM : S_READ;
`else
          w_next = (w_cnt == '0) ? S_DONE : S_READ;
`endif
        end
      end
      S_READ: begin
        if (w_issue && (r_rd_left == ONE)) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (w_pop && (r_beats_left == ONE)) begin
`ifdef LAVA_DRAIN_CHECKSUM_EN
          w_next = S_CSUM;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef LAVA_DRAIN_CHECKSUM_EN
      S_CSUM: begin
        if (w_xfer) w_next = S_DONE;
      end
`endif
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_rd_left    <= '0;
      r_beats_left <= '0;
      r_rd_addr    <= '0;
      r_inflight   <= 1'b0;
      r_infl_last  <= 1'b0;
`ifdef LAVA_DRAIN_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
`ifdef LAVA_DRAIN_CHECKSUM_EN
      r_infl_last <= 1'b0;
`else
      r_infl_last <= w_issue && (r_rd_left == ONE);
`endif
      if ((r_state == S_IDLE) && start) begin
        r_rd_left    <= w_cnt;
        r_beats_left <= w_cnt;
        r_rd_addr    <= '0;
`ifdef LAVA_DRAIN_CHECKSUM_EN
        r_csum       <= '0;
`endif
      end else begin
        if (w_issue) begin
          r_rd_addr <= r_rd_addr + 1'b1;
          r_rd_left <= r_rd_left - ONE;
        end
        if (w_pop) begin
          r_beats_left <= r_beats_left - ONE;
`ifdef LAVA_DRAIN_CHECKSUM_EN
          r_csum       <= r_csum + w_fifo_data;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_lava_result_drain.sv
// Randomized bench for lava_result_drain against a
// queue-based model of the expected beat stream.
module tb_lava_result_drain;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   count = '0;
  logic [AW-1:0] ram_raddr;
  logic          ram_rd_en;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;
  logic          done;

  lava_result_drain #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .count    (count),
    .ram_raddr(ram_raddr),
    .ram_rd_en(ram_rd_en),
    .ram_rdata(ram_rdata),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [8];

  always @(posedge clk) begin
    if (ram_rd_en) ram_rdata <= mem[ram_raddr];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  int rmode = 0;
  int rph = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       begin out_ready = (rph % 3 == 0); rph++; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic [7:0] got_d[$];
  bit         got_l[$];
  int first_cyc, last_cyc, done_cyc, n_done;
  int outst;

  initial begin
    bit pv, pr, pl, pop;
    logic [7:0] pd;
    pv = 0; pr = 0; pl = 0; pd = 0;
    outst = 0; n_done = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        outst = 0;
        pv = 0;
      end else begin
        if (pv && !pr) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, pd);
          check("hold_last", out_last, pl);
        end
        pop = out_valid && out_ready;
        if (ram_rd_en)
          check("no_overflow", (outst - int'(pop)) < 2, 1);
        if (pop) begin
          if (got_d.size() == 0) first_cyc = cyc;
          last_cyc = cyc;
          got_d.push_back(out_data);
          got_l.push_back(out_last);
        end
        if (done) begin
          n_done++;
          done_cyc = cyc;
        end
        outst += int'(ram_rd_en) - int'(pop && outst > 0);
        pv = out_valid; pr = out_ready;
        pd = out_data;  pl = out_last;
      end
    end
  end

  task automatic run_drain(input string nm, input int cnt,
                           input int mode, input bit timing,
                           input bit restart);
    int n, sum, c0, guard, exp_done;
    logic [7:0] exp_q[$];
    n = (cnt > 8) ? 8 : cnt;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mem[i]);
      sum += mem[i];
    end
`ifdef LAVA_DRAIN_CHECKSUM_EN
    exp_q.push_back(sum[7:0]);
`endif
    got_d.delete();
    got_l.delete();
    n_done = 0;
    rmode = mode;
    rph = 0;
    @(posedge clk);
    #2 start = 1'b1;
    count = 4'(cnt);
    @(negedge clk);
    c0 = cyc + 1;
    @(posedge clk);
    #2 start = 1'b0;
    check({nm, "_busy"}, busy, 1);
    if (restart) begin
      repeat (2) @(posedge clk);
      #2 start = 1'b1;
      count = 4'd3;
      @(posedge clk);
      #2 start = 1'b0;
    end
    guard = 0;
    while (n_done == 0 && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    check({nm, "_done_seen"}, n_done != 0, 1);
    repeat (3) @(posedge clk);
    check({nm, "_done_cnt"}, n_done, 1);
    check({nm, "_nbeats"}, got_d.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_d.size()) begin
        check({nm, "_data"}, got_d[i], exp_q[i]);
        check({nm, "_last"}, got_l[i], i == exp_q.size() - 1);
      end
    end
    if (timing) begin
`ifdef LAVA_DRAIN_CHECKSUM_EN
      exp_done = (n == 0) ? c0 + 1 : c0 + 3 + n;
`else
      exp_done = (n == 0) ? c0 : c0 + 2 + n;
`endif
      check({nm, "_done_cyc"}, done_cyc, exp_done);
      if (n > 0) begin
        check({nm, "_first_cyc"}, first_cyc, c0 + 2);
        check({nm, "_last_cyc"}, got_d.size() > n ? 0 : last_cyc,
              got_d.size() > n ? 0 : c0 + 1 + n);
      end
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_raddr"}, ram_raddr, 0);
    check({nm, "_rd_en"}, ram_rd_en, 0);
    check({nm, "_data"}, out_data, 0);
    check({nm, "_valid"}, out_valid, 0);
    check({nm, "_last"}, out_last, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_done"}, done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int g;
    for (int i = 0; i < 8; i++) mem[i] = 8'((i + 1) * 8'h11);
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    #1 rst = 1'b1;

    run_drain("full", 8, 0, 1, 0);

    for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
    run_drain("bp", 4, 1, 0, 0);
    run_drain("cnt0", 0, 0, 1, 0);
    run_drain("cnt9", 9, 0, 1, 0);

    got_d.delete();
    got_l.delete();
    n_done = 0;
    rmode = 0;
    @(posedge clk);
    #2 start = 1'b1;
    count = 4'd6;
    @(posedge clk);
    #2 start = 1'b0;
    g = 0;
    while (got_d.size() < 2 && g < 100) begin
      @(posedge clk);
      g++;
    end
    check("mid_two_beats", got_d.size() >= 2, 1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("mid_rst");
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    check("mid_no_done", n_done, 0);
    run_drain("rst_redo", 6, 0, 1, 0);

    run_drain("busy_start", 8, 0, 1, 1);

    mem[0] = 8'hFF;
    mem[1] = 8'h02;
    mem[2] = 8'h10;
    run_drain("csum", 3, 0, 1, 0);
`ifdef LAVA_DRAIN_CHECKSUM_EN
    check("csum_beat", got_d.size() == 4 ? got_d[3] : 0, 8'h11);
`else
    check("csum_off_last", got_d.size() == 3 ? got_d[2] : 0, 8'h10);
`endif

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
      run_drain("rand", int'($urandom_range(0, 12)), 2, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
